modulo_display_contador_7seg: RTL
=================================

# modulo_display_contador_7seg

Display stage directly downstream of the 7-bit synchronous down counter. It takes the counter's 7-bit value (0–127), converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a time-multiplexed three-digit, common-anode 7-segment display. It re-converts automatically whenever the counter value changes, so the display tracks the counter without any handshake from it.

## Interface
- `INVERT_IN`, default 1: 1 means the input is the complemented count (counter `q_bar` bus) and is inverted internally; 0 means true binary.
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; legal range ≥2.
- `BLANK_ZEROS`, default 1: 1 enables leading-zero blanking.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `q_bar`  in  7  count from the counter stage, polarity per `INVERT_IN`.
- `bcd`  out  12  registered digits {hundreds, tens, units}, 4 bits each.
- `busy`  out  1  high while a conversion is in progress (LOAD, SHIFT, UPDATE).
- `seg`  out  7  segments, active-low; `seg[0]`=a … `seg[6]`=g.
- `an`  out  3  digit enables, active-low; `an[0]`=units, `an[1]`=tens, `an[2]`=hundreds.

## Operation
- `val` = `INVERT_IN` ? ~`q_bar` : `q_bar`.
- FSM states: IDLE, LOAD, SHIFT, UPDATE.
  - IDLE → LOAD when `val` != `last_val` or `valid`=0.
  - LOAD: `shreg` ← {12'b0, `val`}; `last_val` ← `val`; `cnt` ← 0.
  - SHIFT, 7 cycles: each cycle, add 3 to every BCD nibble ≥5, then shift the whole 19-bit register left by 1. Go to UPDATE when `cnt` = 6.
  - UPDATE: `bcd` ← `shreg[18:7]`; `valid` ← 1; go to IDLE.
- Input changes during LOAD, SHIFT or UPDATE are ignored. The new value is picked up by the IDLE comparison that follows.
- Scan:
  - `rcnt` counts 0 … `REFRESH_DIV`-1, then wraps.
  - On wrap, `dig` advances 0→1→2→0.
  - `an` = one-hot-low of `dig`; `seg` = decode(selected nibble).
- Blanking (when `BLANK_ZEROS`=1):
  - Hundreds are blank when 0.
  - Tens are blank when hundreds and tens are both 0.
  - Units are never blank.
  - A blanked digit gives `seg`=1111111 while `an` still scans.
- Decode, active-low `gfedcba`:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibbles ≥10 give 1111111.

## Timing
- Reset state: FSM=IDLE, `valid`=0, `bcd`=0, `busy`=0, `rcnt`=0, `dig`=0.
- Outputs immediately after reset: `an`=110 and `seg`=1000000 (units shows "0").
- Because `valid`=0, the first conversion starts on the first cycle after reset is released.
- `busy` and `bcd` are registered. `an` and `seg` are combinational from registered `dig` and `bcd`; no latch paths.
- Latency: if `val` changes before clock edge N (FSM in IDLE):
  - edge N: IDLE→LOAD; `busy` rises after N.
  - edge N+1: LOAD.
  - edges N+2 … N+8: 7 SHIFT cycles.
  - edge N+9: UPDATE writes `bcd`.
  - `busy` falls after edge N+9. The new `bcd` is visible for N+9 onward, a 9-cycle update latency.
- Back-to-back conversions: a value that differs from `last_val` during UPDATE starts a new LOAD two cycles after UPDATE (UPDATE→IDLE→LOAD).
- `rst` asserted mid-conversion: the conversion aborts and all state returns to reset values on that edge; the partial result is discarded.
- Scan timing: each digit is lit for exactly `REFRESH_DIV` cycles. Scanning is independent of the FSM, and a `bcd` update takes effect on the currently lit digit immediately.

## Structure
- Package `pkg_display`: FSM state encoding, the ten segment patterns, the blank pattern constant.
- Sub-module `modulo_decodificador_7seg`: combinational 4-bit to 7-bit active-low decoder, with a `blank` input that forces 1111111.
- The top holds the FSM, the double-dabble datapath, the change detector and the scan counter.

## Test plan
- **Reset release, value 127:** `INVERT_IN`=1, `q_bar`=0000000, release `rst` → `busy` high for 9 cycles, then `bcd`=12'h127 and `busy`=0.
- **Blanking and scan:** `REFRESH_DIV`=4, `q_bar`=~7'd5 → `bcd`=12'h005.
  - `an` cycles 110, 101, 011, changing every 4 cycles.
  - `seg`=0010010 on units and 1111111 on tens and hundreds.
- **Down-count tracking:** step `val` 10→9, with each step held ≥12 cycles.
  - 10 → `bcd`=12'h010; tens shows 1111001 and units shows 1000000.
  - 9 → `bcd`=12'h009, tens blanked.
- **Change during SHIFT:** `val` 42→99 at cycle 4 of the conversion → `bcd`=12'h042 first, `busy` low for exactly 1 cycle, then `bcd`=12'h099 9 cycles later.
- **Reset mid-conversion:** assert `rst` during SHIFT with `val`=88 → next cycle `bcd`=0, `busy`=0. After release, `bcd`=12'h088 9 cycles later.
- **Exhaustive sweep:** all 128 values, each held 12 cycles → `bcd` equals the decimal of `val` every time, and `seg` matches the decode rules for each `dig`.

Source files
------------

// File: rtl/modulo_display_contador_7seg_pkg.sv
// Shared types and constants for the counter display stage:
// FSM encoding, segment patterns and the double-dabble nibble adjust.
package pkg_display;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_UPDATE
  } state_t;

  // Active-low gfedcba patterns; element [0] is digit 0
  localparam logic [6:0]      SEG_BLANK  = 7'b1111111;
  localparam logic [9:0][6:0] SEG_DIGITS = '{
    7'b0010000, // 9
    7'b0000000, // 8
    7'b1111000, // 7
    7'b0000010, // 6
    7'b0010010, // 5
    7'b0011001, // 4
    7'b0110000, // 3
    7'b0100100, // 2
    7'b1111001, // 1
    7'b1000000  // 0
  };

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/modulo_display_contador_7seg_decodificador.sv
// Combinational BCD nibble to active-low 7-segment decoder with blanking.
module modulo_decodificador_7seg
  import pkg_display::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (nibble <= 4'd9)) begin
      seg = SEG_DIGITS[nibble];
    end
  end

endmodule

// File: rtl/modulo_display_contador_7seg.sv
// Counter display stage: sequential binary-to-BCD conversion that re-runs on
// every input change, plus a three-digit multiplexed common-anode scan.
module modulo_display_contador_7seg
  import pkg_display::*;
#(
  parameter int INVERT_IN   = 1,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_ZEROS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  q_bar,
  output logic [11:0] bcd,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int RW = $clog2(REFRESH_DIV);

  logic [6:0]    val;
  state_t        state_q,    state_d;
  logic [18:0]   shreg_q,    shreg_d;
  logic [18:0]   adj;
  logic [6:0]    last_val_q, last_val_d;
  logic [2:0]    cnt_q,      cnt_d;
  logic          valid_q,    valid_d;
  logic [11:0]   bcd_q,      bcd_d;
  logic          busy_q,     busy_d;
  logic [RW-1:0] rcnt_q,     rcnt_d;
  logic [1:0]    dig_q,      dig_d;
  logic [3:0]    nib;
  logic          blank;

  assign val = (INVERT_IN != 0) ? ~q_bar : q_bar;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    last_val_d = last_val_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    bcd_d      = bcd_q;
    adj        = {add3(shreg_q[18:15]), add3(shreg_q[14:11]),
                  add3(shreg_q[10:7]), shreg_q[6:0]};
    unique case (state_q)
      ST_IDLE: begin
        if ((val != last_val_q) || !valid_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_d    = {12'b0, val};
        last_val_d = val;
        cnt_d      = '0;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        shreg_d = adj << 1;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd6) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        bcd_d   = shreg_q[18:7];
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // busy reflects the state being entered so it rises with LOAD and falls with IDLE
    busy_d = (state_d != ST_IDLE);

    rcnt_d = rcnt_q + 1'b1;
    dig_d  = dig_q;
    if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      dig_d  = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      last_val_q <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      rcnt_q     <= '0;
      dig_q      <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      last_val_q <= last_val_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      rcnt_q     <= rcnt_d;
      dig_q      <= dig_d;
    end
  end

  always_comb begin
    unique case (dig_q)
      2'd0: begin
        nib   = bcd_q[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        nib   = bcd_q[7:4];
        blank = (BLANK_ZEROS != 0) && (bcd_q[11:4] == 8'd0);
      end
      default: begin
        nib   = bcd_q[11:8];
        blank = (BLANK_ZEROS != 0) && (bcd_q[11:8] == 4'd0);
      end
    endcase
  end

  modulo_decodificador_7seg u_dec (
    .nibble (nib),
    .blank  (blank),
    .seg    (seg)
  );

  assign an   = ~(3'b001 << dig_q);
  assign bcd  = bcd_q;
  assign busy = busy_q;

endmodule
